// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter:
// the arbiter FSM state encoding and the character width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bus between the requesters/UART transmitter and the arbiter.
// slave is the arbiter's view; master is the requester/transmitter side.
interface uart_tx_arb_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             gnt;
  logic [IDX_W-1:0]               owner;
  logic                           active;
  logic                           tx_en;
  logic [UART_DATA_W-1:0]         tx_data;
  logic                           tx_busy;
  logic                           tx_done;
  logic                           timeout_err;

  modport slave (
    input  req, req_data, tx_busy, tx_done,
    output gnt, owner, active, tx_en, tx_data, timeout_err
  );

  modport master (
    output req, req_data, tx_busy, tx_done,
    input  gnt, owner, active, tx_en, tx_data, timeout_err
  );

endinterface

// File: rtl/uart_tx_arb_rr.sv
// Round-robin selector: searches from ptr+1 upward (wrapping) and returns
// the first active request as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Define UART_TX_ARB_TIMEOUT_EN to add the WAIT_DONE watchdog (timeout_err).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;

  logic [NUM_REQ-1:0]     win_grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_valid;
  logic [UART_DATA_W-1:0] sel_data;
  logic                   timeout_hit;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr (
    .req   (bus.req),
    .ptr   (owner_q),
    .grant (win_grant),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) sel_data = bus.req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  // LAUNCH spans two cycles: the gnt pulse cycle, then the tx_en cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    tx_data_d = tx_data_q;
    gnt_d     = '0;
    case (state_q)
      IDLE: begin
        if (win_valid && !bus.tx_busy) begin
          state_d   = LAUNCH;
          gnt_d     = win_grant;
          owner_d   = win_idx;
          tx_data_d = sel_data;
        end
      end
      LAUNCH: begin
        if (gnt_q == '0) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= IDX_W'(NUM_REQ - 1);
      tx_data_q <= '0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tx_data_q <= tx_data_d;
      gnt_q     <= gnt_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Counter sits at zero outside WAIT_DONE, so it is clear on every entry.
  always_comb begin
    cnt_d         = (state_q == WAIT_DONE) ? cnt_q + 1'b1 : '0;
    timeout_err_d = (state_q == WAIT_DONE) && !bus.tx_done && timeout_hit;
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.tx_data = tx_data_q;
  assign bus.active  = (state_q != IDLE);
  assign bus.tx_en   = (state_q == LAUNCH) && (gnt_q == '0);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed, self-checking bench for uart_tx_arb (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_arb;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  uart_tx_arb_if #(.NUM_REQ(4)) bus ();

  uart_tx_arb #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=hang required=finish");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [31:0] data,
                               input logic busy, input logic done);
    bus.req      = req;
    bus.req_data = data;
    bus.tx_busy  = busy;
    bus.tx_done  = done;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitGrant(input string tag);
    int n;
    n = 0;
    while (bus.gnt == 4'b0000 && n < 30) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bus.gnt != 4'b0000), 32'd1);
  endtask

  initial begin
    logic any_bad;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);

    // Reset values must appear before any clock edge.
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("rst_tx_en", 32'(bus.tx_en), 32'h0);
    checkOutput("rst_active", 32'(bus.active), 32'h0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h0);
    checkOutput("rst_timeout", 32'(bus.timeout_err), 32'h0);
    checkOutput("rst_owner", 32'(bus.owner), 32'h3);
    tick();
    tick();
    rst = 1'b0;

    // Fairness: all four requesting, done 10 cycles after each tx_en.
    applyStimulus(4'b1111, 32'h13121110, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      waitGrant($sformatf("fair_grant_seen_%0d", g));
      checkOutput($sformatf("fair_gnt_%0d", g), 32'(bus.gnt), 32'(4'b0001 << (g % 4)));
      checkOutput($sformatf("fair_owner_%0d", g), 32'(bus.owner), 32'(g % 4));
      tick();
      checkOutput($sformatf("fair_tx_en_%0d", g), 32'(bus.tx_en), 32'h1);
      checkOutput($sformatf("fair_tx_data_%0d", g), 32'(bus.tx_data), 32'h10 + 32'(g % 4));
      if (g == 4) bus.req = 4'b0000;
      for (int k = 0; k < 10; k++) tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
    checkOutput("fair_end_active", 32'(bus.active), 32'h0);

    // Single request from requester 2 with byte 0xA5.
    applyStimulus(4'b0100, 32'h00A50000, 1'b0, 1'b0);
    checkOutput("single_pre_gnt", 32'(bus.gnt), 32'h0);
    tick();
    checkOutput("single_gnt", 32'(bus.gnt), 32'h4);
    checkOutput("single_owner", 32'(bus.owner), 32'h2);
    checkOutput("single_active", 32'(bus.active), 32'h1);
    checkOutput("single_no_early_tx_en", 32'(bus.tx_en), 32'h0);
    bus.req = 4'b0000;
    bus.tx_done = 1'b1;
    tick();
    checkOutput("single_tx_en", 32'(bus.tx_en), 32'h1);
    checkOutput("single_tx_data", 32'(bus.tx_data), 32'hA5);
    checkOutput("single_gnt_pulse", 32'(bus.gnt), 32'h0);
    bus.tx_done = 1'b0;
    tick();
    checkOutput("single_tx_en_pulse", 32'(bus.tx_en), 32'h0);
    checkOutput("single_wait_active", 32'(bus.active), 32'h1);
    checkOutput("single_tx_data_hold", 32'(bus.tx_data), 32'hA5);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checkOutput("single_done_active", 32'(bus.active), 32'h0);

    // Busy hold-off for 20 cycles.
    applyStimulus(4'b0001, 32'h000000C3, 1'b1, 1'b0);
    any_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.gnt != 4'b0000 || bus.tx_en) any_bad = 1'b1;
    end
    checkOutput("busy_no_grant", 32'(any_bad), 32'h0);
    bus.tx_busy = 1'b0;
    tick();
    checkOutput("busy_release_gnt", 32'(bus.gnt), 32'h1);
    checkOutput("busy_release_owner", 32'(bus.owner), 32'h0);
    bus.req = 4'b0000;
    tick();
    tick();
    checkOutput("busy_wait_active", 32'(bus.active), 32'h1);

    // Collision: tx_done and req[1] in the same cycle.
    applyStimulus(4'b0010, 32'h00005A00, 1'b0, 1'b1);
    tick();
    checkOutput("coll_no_b2b_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("coll_idle", 32'(bus.active), 32'h0);
    bus.tx_done = 1'b0;
    tick();
    checkOutput("coll_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    tick();
    checkOutput("coll_tx_data", 32'(bus.tx_data), 32'h5A);
    tick();
    bus.tx_done = 1'b1;
    tick();
    // Stray tx_done while idle.
    tick();
    bus.tx_done = 1'b0;
    checkOutput("stray_active", 32'(bus.active), 32'h0);
    checkOutput("stray_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("stray_tx_en", 32'(bus.tx_en), 32'h0);
    checkOutput("stray_owner", 32'(bus.owner), 32'h1);

    // Reset in WAIT_DONE.
    applyStimulus(4'b0100, 32'h00770000, 1'b0, 1'b0);
    tick();
    bus.req = 4'b0000;
    tick();
    tick();
    checkOutput("mid_wait_active", 32'(bus.active), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_active", 32'(bus.active), 32'h0);
    checkOutput("mid_rst_tx_data", 32'(bus.tx_data), 32'h0);
    checkOutput("mid_rst_owner", 32'(bus.owner), 32'h3);
    checkOutput("mid_rst_tx_en", 32'(bus.tx_en), 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(4'b1001, 32'h99000011, 1'b0, 1'b0);
    tick();
    checkOutput("post_rst_gnt", 32'(bus.gnt), 32'h1);
    checkOutput("post_rst_owner", 32'(bus.owner), 32'h0);
    bus.req = 4'b0000;
    tick();
    checkOutput("post_rst_tx_data", 32'(bus.tx_data), 32'h11);
    tick();

    // Now in WAIT_DONE with no tx_done forthcoming.
    any_bad = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.timeout_err) any_bad = 1'b1;
    end
    checkOutput("to_no_early_err", 32'(any_bad), 32'h0);
    tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
    checkOutput("to_err_pulse", 32'(bus.timeout_err), 32'h1);
    checkOutput("to_back_idle", 32'(bus.active), 32'h0);
    tick();
    checkOutput("to_err_single", 32'(bus.timeout_err), 32'h0);
`else
    checkOutput("to_err_off", 32'(bus.timeout_err), 32'h0);
    checkOutput("to_still_waiting", 32'(bus.active), 32'h1);
    for (int k = 0; k < 10; k++) tick();
    checkOutput("to_err_off_late", 32'(bus.timeout_err), 32'h0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checkOutput("to_off_done_idle", 32'(bus.active), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
